// File: rtl/bram_stream_reader.sv
// Read-side sequencer for one BRAM port: walks a commanded address range and
// presents the words as a ready/valid stream through a two-entry credit-managed buffer.
`timescale 1ns/1ps
module bram_stream_reader #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ADDR-1:0] cmd_base,
    input  logic [ADDR:0]   cmd_count,
    output logic [ADDR-1:0] bram_req_addr,
    output logic            bram_req_writeEn,
    output logic [DATA-1:0] bram_req_writeData,
    input  logic [DATA-1:0] bram_rsp_readData,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            done
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR:0]   CNT_ZERO = {(ADDR+1){1'b0}};
    localparam logic [ADDR:0]   CNT_ONE  = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR-1:0] PTR_ONE  = {{(ADDR-1){1'b0}}, 1'b1};

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [ADDR-1:0] rd_ptr_r;
    logic [ADDR:0]   issue_left_r;
    logic [ADDR:0]   beats_left_r;
    logic            inflight_r;
    logic            done_r;
    logic [DATA-1:0] fifo_mem_r [2];
    logic            head_r;
    logic            tail_r;
    logic [1:0]      fifo_count_r;
    logic            pop_s;
    logic            issue_s;
    logic            final_pop_s;
    logic [2:0]      occupancy_s;

    // Handshake, credit check and read-issue qualification
    always_comb begin
        pop_s       = (fifo_count_r != 2'd0) && out_ready;
        // Occupancy counts buffered words plus the one in flight, less the word leaving now
        occupancy_s = {1'b0, fifo_count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if ((state_r == ST_RUN) && (issue_left_r != CNT_ZERO) && (occupancy_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        final_pop_s = (state_r == ST_DRAIN) && pop_s && (beats_left_r == CNT_ONE);
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && (cmd_count != CNT_ZERO)) state_nxt_s = ST_RUN;
                else                                      state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (issue_s && (issue_left_r == CNT_ONE)) state_nxt_s = ST_DRAIN;
                else                                      state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (final_pop_s) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer: state, address walk, issue/beat counters, done pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            rd_ptr_r     <= {ADDR{1'b0}};
            issue_left_r <= CNT_ZERO;
            beats_left_r <= CNT_ZERO;
            inflight_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= issue_s;
            done_r     <= final_pop_s || ((state_r == ST_IDLE) && cmd_valid && (cmd_count == CNT_ZERO));
            if ((state_r == ST_IDLE) && cmd_valid) begin
                rd_ptr_r     <= cmd_base;
                issue_left_r <= cmd_count;
                beats_left_r <= cmd_count;
            end else begin
                if (issue_s) begin
                    rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                    issue_left_r <= issue_left_r - CNT_ONE;
                end
                if (pop_s) begin
                    beats_left_r <= beats_left_r - CNT_ONE;
                end
            end
        end
    end

    // Two-entry output buffer; the BRAM response is captured the cycle after its issue
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fifo_mem_r[0] <= {DATA{1'b0}};
            fifo_mem_r[1] <= {DATA{1'b0}};
            head_r        <= 1'b0;
            tail_r        <= 1'b0;
            fifo_count_r  <= 2'd0;
        end else begin
            if (inflight_r) begin
                fifo_mem_r[tail_r] <= bram_rsp_readData;
                tail_r             <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            fifo_count_r <= fifo_count_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

    assign cmd_ready          = (state_r == ST_IDLE);
    assign busy               = (state_r != ST_IDLE);
    assign done               = done_r;
    assign bram_req_addr      = rd_ptr_r;
    assign bram_req_writeEn   = 1'b0;
    assign bram_req_writeData = {DATA{1'b0}};
    assign out_valid          = (fifo_count_r != 2'd0);
    assign out_data           = fifo_mem_r[head_r];
    assign out_last           = out_valid && (beats_left_r == CNT_ONE);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: commands push expected beats, a monitor
// pops and compares every accepted output beat.
`timescale 1ns/1ps
module tb_bram_stream_reader;
    localparam int DATA = 72;
    localparam int ADDR = 10;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [DATA-1:0] data;
        logic            last;
    } exp_t;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [ADDR-1:0] cmd_base = '0;
    logic [ADDR:0]   cmd_count = '0;
    logic [ADDR-1:0] bram_req_addr;
    logic            bram_req_writeEn;
    logic [DATA-1:0] bram_req_writeData;
    logic [DATA-1:0] bram_rsp_readData = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DATA-1:0] out_data;
    logic            out_last;
    logic            busy;
    logic            done;

    logic [DATA-1:0] mem [DEPTH];
    exp_t            exp_q [$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              rise_cyc = -1;
    int              last_cyc = -1;
    int              valid_cycles = 0;
    logic [39:0]     pat = 40'b1111100000_0000011011_0100111010_1100101101;

    bram_stream_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .bram_req_addr(bram_req_addr), .bram_req_writeEn(bram_req_writeEn),
        .bram_req_writeData(bram_req_writeData), .bram_rsp_readData(bram_rsp_readData),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // BRAM port model with one-cycle registered read
    always @(posedge clock) bram_rsp_readData <= mem[bram_req_addr];

    function automatic logic [DATA-1:0] word_of(input int k);
        return {8'h5A, ~k, k};
    endfunction

    task automatic check(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic send_cmd(input int base, input int count, output int c0);
        exp_t e;
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
        end
        cmd_valid = 1'b1;
        cmd_base  = base[ADDR-1:0];
        cmd_count = count[ADDR:0];
        c0 = cyc;
        for (int i = 0; i < count; i++) begin
            e.data = word_of((base + i) % DEPTH);
            e.last = (i == count - 1);
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_done(input bit use_pat, input int max_cyc, output int dc);
        dc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            if (use_pat) out_ready = pat[i % 40];
            else         out_ready = 1'b1;
            if (done) begin
                dc = cyc;
                check("done_cmd_ready", cmd_ready, 1);
                check("done_busy", busy, 0);
                break;
            end
        end
        if (dc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", max_cyc);
        end
    endtask

    // Monitor: scoreboard pops, stall stability and constant write-side checks
    initial begin : monitor
        exp_t        e;
        logic        stall_prev;
        logic        prev_valid;
        logic [DATA-1:0] held;
        stall_prev = 1'b0;
        prev_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            #2;
            if (!resetn) begin
                stall_prev = 1'b0;
                prev_valid = 1'b0;
            end else begin
                check("write_en", bram_req_writeEn, 0);
                check("write_data", bram_req_writeData, 0);
                if (stall_prev) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, held);
                end
                if (out_valid && !prev_valid) rise_cyc = cyc;
                if (out_valid) valid_cycles++;
                prev_valid = out_valid;
                if (!out_valid) check("last_without_valid", out_last, 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_last", out_last, e.last);
                        if (out_last) last_cyc = cyc;
                    end
                end
                stall_prev = out_valid && !out_ready;
                held = out_data;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c0;
        int dc;
        int vc;
        for (int k = 0; k < DEPTH; k++) mem[k] = word_of(k);

        // Reset values
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_addr", bram_req_addr, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // base 5, count 4, continuous ready
        out_ready = 1'b1;
        send_cmd(5, 4, c0);
        run_until_done(1'b0, 40, dc);
        check_int("b5_first_valid_cycle", rise_cyc - c0, 3);
        check_int("b5_last_cycle", last_cyc - c0, 6);
        check_int("b5_done_cycle", dc - c0, 7);
        check_int("b5_queue_empty", exp_q.size(), 0);

        // Address wrap at the top of the BRAM
        send_cmd(1022, 4, c0);
        run_until_done(1'b0, 40, dc);
        check_int("wrap_done_cycle", dc - c0, 7);
        check_int("wrap_queue_empty", exp_q.size(), 0);

        // Backpressure pattern including a 10-cycle stall
        send_cmd(100, 16, c0);
        run_until_done(1'b1, 300, dc);
        check_int("bp_queue_empty", exp_q.size(), 0);
        out_ready = 1'b1;

        // Zero-count command
        vc = valid_cycles;
        send_cmd(7, 0, c0);
        run_until_done(1'b0, 10, dc);
        check_int("zero_done_cycle", dc - c0, 1);
        check_int("zero_no_valid", valid_cycles - vc, 0);

        // Asynchronous reset mid-command with a full buffer
        out_ready = 1'b0;
        send_cmd(200, 16, c0);
        repeat (6) @(negedge clock);
        #3;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clock);
        #3;
        resetn = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check("post_rst_done", done, 0);

        // Full range, then a back-to-back command in the done cycle
        send_cmd(0, 1024, c0);
        run_until_done(1'b0, 1100, dc);
        check_int("full_first_valid_cycle", rise_cyc - c0, 3);
        check_int("full_last_cycle", last_cyc - c0, 1026);
        check_int("full_done_cycle", dc - c0, 1027);
        send_cmd(10, 3, c0);
        check_int("b2b_accept_cycle", c0, dc);
        run_until_done(1'b0, 40, dc);
        check_int("b2b_first_valid_cycle", rise_cyc - c0, 3);
        check_int("b2b_last_cycle", last_cyc - c0, 5);
        check_int("b2b_done_cycle", dc - c0, 6);
        check_int("final_queue_empty", exp_q.size(), 0);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
